// File: rtl/seq_divider_8bit_pkg.sv
// Shared types and constants for the sequential restoring divider.
// Build option: SIGNED_DIV_EN selects two's-complement operands.
package seq_divider_8bit_pkg;

    localparam int DIV_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } divState_t;

    function automatic int cntWidth(input int w);
        return $clog2(w + 1);
    endfunction

    localparam int CNT_W = cntWidth(DIV_WIDTH);

endpackage

// File: rtl/seq_divider_8bit_if.sv
// Start/busy/done handshake and operand/result bus of the divider.
// The controller owns the master side, the divider the slave side.
interface seq_divider_8bit_if
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);

    logic             iStart;
    logic [WIDTH-1:0] iDividend;
    logic [WIDTH-1:0] iDivisor;
    logic [WIDTH-1:0] oQuotient;
    logic [WIDTH-1:0] oRemainder;
    logic             oBusy;
    logic             oDone;
    logic             oDivByZero;

    modport master (
        output iStart,
        output iDividend,
        output iDivisor,
        input  oQuotient,
        input  oRemainder,
        input  oBusy,
        input  oDone,
        input  oDivByZero
    );

    modport slave (
        input  iStart,
        input  iDividend,
        input  iDivisor,
        output oQuotient,
        output oRemainder,
        output oBusy,
        output oDone,
        output oDivByZero
    );

endinterface

// File: rtl/seq_divider_8bit_div_trial_sub.sv
// Trial subtractor: difference at WIDTH+1 bits plus a borrow that
// tells the divider to restore the shifted remainder.
module div_trial_sub
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic [WIDTH:0] minuend,
    input  logic [WIDTH:0] subtrahend,
    output logic [WIDTH:0] diff,
    output logic           borrow
);

    always_comb begin
        {borrow, diff} = {1'b0, minuend} - {1'b0, subtrahend};
    end

endmodule

// File: rtl/seq_divider_8bit.sv
// Sequential restoring divider, one trial subtraction per clock.
// Build option: SIGNED_DIV_EN (two's-complement operands and results).
module seq_divider_8bit
    import seq_divider_8bit_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic               iClk,
    input  logic               iRst,
    seq_divider_8bit_if.slave  bus
);

    localparam int CW = cntWidth(WIDTH);
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(1);

    divState_t state;
    divState_t stateNext;

    logic [WIDTH-1:0] qWork;
    logic [WIDTH:0]   remWork;
    logic [WIDTH-1:0] divisorReg;
    logic [CW-1:0]    count;

    logic [WIDTH-1:0] quotReg;
    logic [WIDTH-1:0] remReg;
    logic             dbzReg;

    logic             accept;
    logic             divisorZero;
    logic             lastStep;
    logic [WIDTH:0]   remShift;
    logic [WIDTH:0]   diff;
    logic             borrow;
    logic [WIDTH-1:0] qStep;
    logic [WIDTH:0]   rStep;
    logic [WIDTH-1:0] rLow;
    logic [WIDTH-1:0] quotFix;
    logic [WIDTH-1:0] remFix;
    logic [WIDTH-1:0] dividendMag;
    logic [WIDTH-1:0] divisorMag;

    assign accept      = bus.iStart && (state != RUN);
    assign divisorZero = (bus.iDivisor == '0);
    assign lastStep    = (count == CNT_LAST);

    // Shift wraps at WIDTH+1 bits; the top bit is always clear after a step.
    assign remShift = (remWork << 1) | {{WIDTH{1'b0}}, qWork[WIDTH-1]};

    div_trial_sub #(
        .WIDTH (WIDTH)
    ) uSub (
        .minuend    (remShift),
        .subtrahend ({1'b0, divisorReg}),
        .diff       (diff),
        .borrow     (borrow)
    );

    assign qStep = {qWork[WIDTH-2:0], ~borrow};
    assign rStep = borrow ? remShift : diff;
    assign rLow  = WIDTH'(rStep);

`ifdef SIGNED_DIV_EN
    logic negQ;
    logic negR;

    assign dividendMag = bus.iDividend[WIDTH-1] ? -bus.iDividend : bus.iDividend;
    assign divisorMag  = bus.iDivisor[WIDTH-1]  ? -bus.iDivisor  : bus.iDivisor;
    assign quotFix     = negQ ? -qStep : qStep;
    assign remFix      = negR ? -rLow  : rLow;

    always_ff @(posedge iClk) begin
        if (iRst) begin
            negQ <= 1'b0;
            negR <= 1'b0;
        end else if (accept) begin
            negQ <= bus.iDividend[WIDTH-1] ^ bus.iDivisor[WIDTH-1];
            negR <= bus.iDividend[WIDTH-1];
        end
    end
`else
    assign dividendMag = bus.iDividend;
    assign divisorMag  = bus.iDivisor;
    assign quotFix     = qStep;
    assign remFix      = rLow;
`endif

    always_comb begin
        stateNext = state;
        unique case (state)
            IDLE: begin
                if (bus.iStart) begin
                    stateNext = divisorZero ? DONE : RUN;
                end
            end
            RUN: begin
                if (lastStep) begin
                    stateNext = DONE;
                end
            end
            DONE: begin
                if (bus.iStart) begin
                    stateNext = divisorZero ? DONE : RUN;
                end else begin
                    stateNext = IDLE;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    always_ff @(posedge iClk) begin
        if (iRst) begin
            state      <= IDLE;
            qWork      <= '0;
            remWork    <= '0;
            divisorReg <= '0;
            count      <= '0;
            quotReg    <= '0;
            remReg     <= '0;
            dbzReg     <= 1'b0;
        end else begin
            state <= stateNext;
            if (accept) begin
                qWork      <= dividendMag;
                remWork    <= '0;
                divisorReg <= divisorMag;
                count      <= CNT_INIT;
                dbzReg     <= divisorZero;
                if (divisorZero) begin
                    quotReg <= '1;
                    remReg  <= bus.iDividend;
                end
            end else if (state == RUN) begin
                qWork   <= qStep;
                remWork <= rStep;
                count   <= count - 1'b1;
                if (lastStep) begin
                    quotReg <= quotFix;
                    remReg  <= remFix;
                end
            end
        end
    end

    assign bus.oQuotient  = quotReg;
    assign bus.oRemainder = remReg;
    assign bus.oDivByZero = dbzReg;
    assign bus.oBusy      = (state == RUN);
    assign bus.oDone      = (state == DONE);

endmodule

// File: tb/tb_seq_divider_8bit.sv
// Scoreboard bench for the sequential divider.
// Build option: SIGNED_DIV_EN switches the reference model to signed.
module tb_seq_divider_8bit;

    localparam int W = 8;

    typedef struct {
        logic [W-1:0] q;
        logic [W-1:0] r;
        logic         dbz;
        int           lat;
    } exp_t;

    logic clk;
    logic rst;

    int asserts;
    int failures;

    exp_t sb[$];

    seq_divider_8bit_if #(.WIDTH(W)) bus ();

    seq_divider_8bit #(.WIDTH(W)) dut (
        .iClk (clk),
        .iRst (rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        if (b == '0) begin
            e.q   = '1;
            e.r   = a;
            e.dbz = 1'b1;
            e.lat = 0;
        end else begin
`ifdef SIGNED_DIV_EN
            int sa;
            int sb2;
            sa    = int'($signed(a));
            sb2   = int'($signed(b));
            e.q   = W'(sa / sb2);
            e.r   = W'(sa % sb2);
`else
            e.q   = a / b;
            e.r   = a % b;
`endif
            e.dbz = 1'b0;
            e.lat = W;
        end
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic startOp(input logic [W-1:0] a, input logic [W-1:0] b);
        bus.iStart    = 1'b1;
        bus.iDividend = a;
        bus.iDivisor  = b;
        sb.push_back(model(a, b));
        tick();
        bus.iStart = 1'b0;
    endtask

    task automatic waitDone(output int lat, output int busyCyc, output bit ok);
        lat     = 0;
        busyCyc = 0;
        while (!bus.oDone && lat < 40) begin
            if (bus.oBusy) busyCyc++;
            tick();
            lat++;
        end
        ok = bus.oDone;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.iStart    = 1'b1;
        bus.iDividend = 8'd50;
        bus.iDivisor  = 8'd5;
        tick();
        tick();
        bus.iStart = 1'b0;
        rst = 1'b0;
        asserts++;
        if (bus.oQuotient !== 8'd0) begin
            failures++;
            $display("FAIL reset_q got %0h want 0", bus.oQuotient);
        end
        asserts++;
        if (bus.oRemainder !== 8'd0) begin
            failures++;
            $display("FAIL reset_r got %0h want 0", bus.oRemainder);
        end
        asserts++;
        if ({bus.oBusy, bus.oDone, bus.oDivByZero} !== 3'b000) begin
            failures++;
            $display("FAIL reset_flags got %b want 000",
                     {bus.oBusy, bus.oDone, bus.oDivByZero});
        end
    endtask

    task automatic test_basic();
        logic [W-1:0] ta[5] = '{8'd100, 8'd255, 8'd5, 8'd0, 8'd200};
        logic [W-1:0] tb[5] = '{8'd7,   8'd1,   8'd9, 8'd3, 8'd200};
        int lat;
        int bc;
        bit ok;
        exp_t e;
        for (int i = 0; i < 5; i++) begin
            startOp(ta[i], tb[i]);
            waitDone(lat, bc, ok);
            e = sb.pop_front();
            asserts++;
            if (!ok) begin
                failures++;
                $display("FAIL basic%0d_timeout no done after %0d edges", i, lat);
                continue;
            end
            asserts++;
            if (lat !== e.lat) begin
                failures++;
                $display("FAIL basic%0d_lat got %0d want %0d", i, lat, e.lat);
            end
            asserts++;
            if (bc !== W) begin
                failures++;
                $display("FAIL basic%0d_busy got %0d want %0d", i, bc, W);
            end
            asserts++;
            if ({bus.oQuotient, bus.oRemainder, bus.oDivByZero} !== {e.q, e.r, e.dbz}) begin
                failures++;
                $display("FAIL basic%0d_result got q=%0h r=%0h z=%b want q=%0h r=%0h z=%b",
                         i, bus.oQuotient, bus.oRemainder, bus.oDivByZero, e.q, e.r, e.dbz);
            end
            tick();
            asserts++;
            if ({bus.oDone, bus.oQuotient} !== {1'b0, e.q}) begin
                failures++;
                $display("FAIL basic%0d_hold got done=%b q=%0h want done=0 q=%0h",
                         i, bus.oDone, bus.oQuotient, e.q);
            end
        end
    endtask

    task automatic test_div_by_zero();
        int lat;
        int bc;
        bit ok;
        exp_t e;
        startOp(8'd37, 8'd0);
        waitDone(lat, bc, ok);
        e = sb.pop_front();
        asserts++;
        if (!ok || lat !== e.lat) begin
            failures++;
            $display("FAIL dbz_lat got ok=%b lat=%0d want lat=%0d", ok, lat, e.lat);
        end
        asserts++;
        if ({bus.oQuotient, bus.oRemainder, bus.oDivByZero} !== {8'hFF, 8'd37, 1'b1}) begin
            failures++;
            $display("FAIL dbz_result got q=%0h r=%0h z=%b want q=ff r=25 z=1",
                     bus.oQuotient, bus.oRemainder, bus.oDivByZero);
        end
        tick();
        startOp(8'd10, 8'd3);
        asserts++;
        if (bus.oDivByZero !== 1'b0) begin
            failures++;
            $display("FAIL dbz_clear got %b want 0", bus.oDivByZero);
        end
        waitDone(lat, bc, ok);
        e = sb.pop_front();
        asserts++;
        if (!ok || {bus.oQuotient, bus.oRemainder, bus.oDivByZero} !== {e.q, e.r, e.dbz}) begin
            failures++;
            $display("FAIL dbz_next got ok=%b q=%0h r=%0h want q=%0h r=%0h",
                     ok, bus.oQuotient, bus.oRemainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_reset_mid_op();
        int lat;
        int bc;
        bit ok;
        int doneSeen;
        exp_t e;
        startOp(8'd200, 8'd13);
        tick();
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        sb.delete();
        asserts++;
        if ({bus.oQuotient, bus.oRemainder, bus.oBusy, bus.oDone, bus.oDivByZero} !== '0) begin
            failures++;
            $display("FAIL midrst_outputs got q=%0h r=%0h b=%b d=%b z=%b want all 0",
                     bus.oQuotient, bus.oRemainder, bus.oBusy, bus.oDone, bus.oDivByZero);
        end
        doneSeen = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus.oDone || bus.oBusy) doneSeen++;
            tick();
        end
        asserts++;
        if (doneSeen !== 0) begin
            failures++;
            $display("FAIL midrst_quiet got %0d active cycles want 0", doneSeen);
        end
        startOp(8'd200, 8'd13);
        waitDone(lat, bc, ok);
        e = sb.pop_front();
        asserts++;
        if (!ok || {bus.oQuotient, bus.oRemainder} !== {e.q, e.r}) begin
            failures++;
            $display("FAIL midrst_redo got ok=%b q=%0h r=%0h want q=%0h r=%0h",
                     ok, bus.oQuotient, bus.oRemainder, e.q, e.r);
        end
        tick();
    endtask

    task automatic test_ignored_start();
        int lat;
        int bc;
        bit ok;
        exp_t e;
        startOp(8'd77, 8'd5);
        tick();
        tick();
        bus.iStart    = 1'b1;
        bus.iDividend = 8'd9;
        bus.iDivisor  = 8'd3;
        tick();
        bus.iStart = 1'b0;
        waitDone(lat, bc, ok);
        lat = lat + 3;
        e = sb.pop_front();
        asserts++;
        if (!ok || lat !== e.lat) begin
            failures++;
            $display("FAIL ignore_lat got ok=%b lat=%0d want %0d", ok, lat, e.lat);
        end
        asserts++;
        if ({bus.oQuotient, bus.oRemainder} !== {e.q, e.r}) begin
            failures++;
            $display("FAIL ignore_result got q=%0h r=%0h want q=%0h r=%0h",
                     bus.oQuotient, bus.oRemainder, e.q, e.r);
        end
        tick();
        asserts++;
        if ({bus.oBusy, bus.oDone} !== 2'b00) begin
            failures++;
            $display("FAIL ignore_idle got busy=%b done=%b want 00", bus.oBusy, bus.oDone);
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        int bc;
        bit ok;
        exp_t e;
        startOp(8'd250, 8'd10);
        waitDone(lat, bc, ok);
        e = sb.pop_front();
        asserts++;
        if (!ok || {bus.oQuotient, bus.oRemainder} !== {e.q, e.r}) begin
            failures++;
            $display("FAIL b2b_first got ok=%b q=%0h r=%0h want q=%0h r=%0h",
                     ok, bus.oQuotient, bus.oRemainder, e.q, e.r);
        end
        startOp(8'd99, 8'd4);
        waitDone(lat, bc, ok);
        e = sb.pop_front();
        asserts++;
        if (!ok || lat !== e.lat) begin
            failures++;
            $display("FAIL b2b_lat got ok=%b lat=%0d want %0d", ok, lat, e.lat);
        end
        asserts++;
        if ({bus.oQuotient, bus.oRemainder} !== {e.q, e.r}) begin
            failures++;
            $display("FAIL b2b_second got q=%0h r=%0h want q=%0h r=%0h",
                     bus.oQuotient, bus.oRemainder, e.q, e.r);
        end
        tick();
    endtask

`ifdef SIGNED_DIV_EN
    task automatic test_signed();
        logic [W-1:0] ta[3] = '{8'h9C, 8'd100, 8'h80};
        logic [W-1:0] tb[3] = '{8'd7,  8'hF9,  8'hFF};
        logic [W-1:0] wq[3] = '{8'hF2, 8'hF2,  8'h80};
        logic [W-1:0] wr[3] = '{8'hFE, 8'h02,  8'h00};
        int lat;
        int bc;
        bit ok;
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            startOp(ta[i], tb[i]);
            waitDone(lat, bc, ok);
            e = sb.pop_front();
            asserts++;
            if (!ok || lat !== e.lat) begin
                failures++;
                $display("FAIL signed%0d_lat got ok=%b lat=%0d want %0d", i, ok, lat, e.lat);
            end
            asserts++;
            if ({bus.oQuotient, bus.oRemainder} !== {wq[i], wr[i]}) begin
                failures++;
                $display("FAIL signed%0d_result got q=%0h r=%0h want q=%0h r=%0h",
                         i, bus.oQuotient, bus.oRemainder, wq[i], wr[i]);
            end
            tick();
        end
    endtask
`endif

    initial begin
        asserts       = 0;
        failures      = 0;
        rst           = 1'b0;
        bus.iStart    = 1'b0;
        bus.iDividend = '0;
        bus.iDivisor  = '0;
        #2;
        test_reset();
        test_basic();
        test_div_by_zero();
        test_reset_mid_op();
        test_ignored_start();
        test_back_to_back();
`ifdef SIGNED_DIV_EN
        test_signed();
`endif
        asserts++;
        if (sb.size() !== 0) begin
            failures++;
            $display("FAIL sb_empty got %0d entries want 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", asserts, failures);
        $finish;
    end

endmodule

// File: doc/seq_divider_8bit.md
Name: seq_divider_8bit

Overview:
- Sequential restoring divider for the SAP-2 ALU; performs the inverse of the add/subtract path, using one trial subtraction per cycle.
- Unsigned WIDTH-bit dividend / divisor produce a quotient and a remainder.
- Sits beside the adder/subtractor; the controller drives it with a start/busy/done handshake.

Parameters:
- WIDTH, 8, operand/result width in bits; must be >= 2.

Ports:
- iClk  in  1  system clock, rising-edge active.
- iRst  in  1  synchronous, active-high reset.
- iStart  in  1  request a division; sampled only when not busy.
- iDividend  in  WIDTH  dividend, latched on the accepted start edge.
- iDivisor  in  WIDTH  divisor, latched on the accepted start edge.
- oQuotient  out  WIDTH  quotient, valid from oDone until the next accepted start.
- oRemainder  out  WIDTH  remainder, valid from oDone until the next accepted start.
- oBusy  out  1  high while the division is in progress.
- oDone  out  1  one-cycle pulse when the result becomes valid.
- oDivByZero  out  1  error flag, valid with the result.

Behaviour:
- Clock and reset: one clock, iClk. iRst is synchronous and active-high. On reset, state=IDLE and oQuotient=0, oRemainder=0, oBusy=0, oDone=0, oDivByZero=0.
- States: IDLE, RUN, DONE.
  - IDLE: iStart=1 at an edge latches the operands and clears Q, R and the step counter.
    - If the divisor is nonzero, go to RUN with counter=WIDTH.
    - If the divisor is 0, go to DONE.
  - RUN: one step per edge:
    - R' = {R[WIDTH-1:0], Q[WIDTH-1]}; Q shifts left by 1.
    - T = R' - D, computed at WIDTH+1 bits.
    - If T is nonnegative, R=T and Q[0]=1; otherwise R=R' and Q[0]=0.
    - The counter decrements. After the WIDTH-th step, go to DONE.
  - DONE: lasts exactly one cycle with oDone=1.
    - Next state is IDLE, or RUN/DONE if iStart=1 (back-to-back start accepted in DONE).
- Latency: oDone rises at the WIDTH-th edge after the start edge (8 by default). For divide-by-zero, oDone rises at the 1st edge.
- oBusy: equals (state==RUN).
- Ignored start: iStart is ignored while oBusy=1; operands changing during RUN have no effect.
- Divide by zero: oQuotient = all ones, oRemainder = dividend, oDivByZero=1.
- oDivByZero clears on the next accepted start.
- Output hold: oQuotient and oRemainder hold their last result until the next accepted start. They are not updated mid-run; the internal working registers are separate.
- Reset mid-operation: abort immediately to the reset values. No oDone is produced.
- Simultaneous iRst and iStart: reset wins.
- Results: dividend < divisor gives Q=0, R=dividend. Dividend 0 gives Q=0, R=0.
- Working-register widths: remainder register is WIDTH+1 bits to hold the borrow; all arithmetic wraps at that width.

Optional Feature:
- Macro: SIGNED_DIV_EN.
- Defined: operands are two's complement.
  - Magnitudes are taken at the start edge.
  - Quotient is negated if the operand signs differ, truncating toward zero.
  - Remainder takes the sign of the dividend.
  - Sign fix-up is applied combinationally on the DONE transition, so latency is unchanged.
  - Divide-by-zero results are unchanged.
- Undefined: unsigned only; no sign logic is synthesized.

Decomposition:
- Shared package holds:
  - default DIV_WIDTH=8;
  - the state encoding (IDLE=2'b00, RUN=2'b01, DONE=2'b10);
  - the counter width constant, $clog2(WIDTH+1).
- One sub-module, div_trial_sub: a (WIDTH+1)-bit subtractor that outputs the difference and a borrow (borrow=1 means restore).
- The FSM, counter and registers stay in the top module.

Test Plan:
- Basic divide: start with 100 / 7 -> oDone at edge 8, Q=14, R=2, oDivByZero=0; oBusy high for 8 cycles.
- Full-scale and small-dividend cases:
  - 255 / 1 -> Q=255, R=0.
  - 5 / 9 -> Q=0, R=5.
  - 0 / 3 -> Q=0, R=0.
- Divide by zero: 37 / 0 -> oDone at edge 1, Q=8'hFF, R=37, oDivByZero=1; then 10 / 3 -> oDivByZero clears, Q=3, R=1.
- Reset mid-operation: assert iRst at run step 4 of 200 / 13 -> next edge all outputs 0 and state IDLE; no oDone pulse; a subsequent 200 / 13 -> Q=15, R=5.
- Handshake:
  - iStart pulsed during RUN with different operands -> ignored; the original result is delivered.
  - iStart held high in the DONE cycle -> new division accepted; second oDone arrives exactly 8 edges later.
- With SIGNED_DIV_EN defined:
  - -100 / 7 -> Q=8'hF2 (-14), R=8'hFE (-2).
  - 100 / -7 -> Q=8'hF2, R=2.
  - -128 / -1 -> Q=8'h80 (wraps), R=0.
